// File: rtl/tbu_sched_pkg.sv
// tbu_sched_pkg: shared constants and types for the traceback scheduler.
//   NBANK / DEPTH     survivor memory geometry (banks x words per bank)
//   BANK_W / ADDR_W   widths of bank selects and word addresses
//   state_t           scheduler FSM states (IDLE / TRAIN / DECODE)
//   bank_inc()        next bank index, wrapping NBANK-1 -> 0
package tbu_sched_pkg;

  localparam int NBANK  = 4;
  localparam int DEPTH  = 16;
  localparam int BANK_W = $clog2(NBANK);
  localparam int ADDR_W = $clog2(DEPTH);

  localparam logic [ADDR_W-1:0] ADDR_LAST  = ADDR_W'(DEPTH - 1);
  // An epoch needs one bank to train on and one to decode.
  localparam logic [1:0]        PEND_TRAIN = 2'd2;
  // With three complete banks pending, the only free bank is the one being written.
  localparam logic [1:0]        PEND_FULL  = 2'd3;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    TRAIN  = 2'd1,
    DECODE = 2'd2
  } state_t;

  // Bank arithmetic relies on the bank select width wrapping naturally.
  function automatic logic [BANK_W-1:0] bank_inc(input logic [BANK_W-1:0] b);
    return b + 2'd1;
  endfunction

endpackage

// File: rtl/tbs_dncnt.sv
// tbs_dncnt: 4-bit loadable down-counter with terminal-count flag.
//   clk, rst     clock, asynchronous active-low reset
//   load         load load_val (has priority over en)
//   en           decrement by one
//   load_val     value loaded on load
//   count_nxt    value the counter takes at the next edge
//   tc           current count is zero
module tbs_dncnt
  import tbu_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              load,
  input  logic              en,
  input  logic [ADDR_W-1:0] load_val,
  output logic [ADDR_W-1:0] count_nxt,
  output logic              tc
);

  logic [ADDR_W-1:0] count;

  // Next count: load beats decrement, otherwise hold.
  always_comb begin
    count_nxt = count;
    if (load) begin
      count_nxt = load_val;
    end else if (en) begin
      count_nxt = count - 4'd1;
    end else begin
      count_nxt = count;
    end
  end

  // Count register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 4'd0;
    end else begin
      count <= count_nxt;
    end
  end

  assign tc = (count == 4'd0);

endmodule

// File: rtl/tbu_sched.sv
// tbu_sched: survivor-memory write/read scheduler for a traceback unit.
//   clk, rst              clock, asynchronous active-low reset
//   in_valid / in_ready   ACS decision vector handshake
//   wr_en/wr_bank/wr_addr survivor-memory write port
//   rd_bank_0/rd_addr_0   training read port (TBU d_in_0)
//   rd_bank_1/rd_addr_1   decode read port (TBU d_in_1)
//   tbu_enable            TBU enable, aligned with read data
//   tbu_selection         0 = training, 1 = decode, aligned with read data
//   epoch_done            one-cycle pulse after a bank has been decoded
//   banks_pending         completed, not-yet-decoded banks
module tbu_sched
  import tbu_sched_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              wr_en,
  output logic [BANK_W-1:0] wr_bank,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [BANK_W-1:0] rd_bank_0,
  output logic [ADDR_W-1:0] rd_addr_0,
  output logic [BANK_W-1:0] rd_bank_1,
  output logic [ADDR_W-1:0] rd_addr_1,
  output logic              tbu_enable,
  output logic              tbu_selection,
  output logic              epoch_done,
  output logic [1:0]        banks_pending
);

  state_t            state;
  state_t            state_nxt;
  logic [BANK_W-1:0] oldest;
  logic [BANK_W-1:0] oldest_nxt;
  logic [1:0]        pending_nxt;
  logic              bank_done;
  logic              dec_done;
  logic              cnt_load;
  logic              cnt_en;
  logic              cnt_tc;
  logic [ADDR_W-1:0] cnt_nxt;

  assign wr_en     = in_valid & in_ready;
  assign bank_done = wr_en & (wr_addr == ADDR_LAST);
  assign dec_done  = (state == DECODE) & cnt_tc;

  // A bank completing and a decode finishing in the same cycle cancel out.
  always_comb begin
    pending_nxt = banks_pending;
    case ({bank_done, dec_done})
      2'b10:   pending_nxt = banks_pending + 2'd1;
      2'b01:   pending_nxt = banks_pending - 2'd1;
      default: pending_nxt = banks_pending;
    endcase
    if (dec_done) begin
      oldest_nxt = bank_inc(oldest);
    end else begin
      oldest_nxt = oldest;
    end
  end

  // FSM next state and counter reload; DECODE may chain straight into TRAIN.
  always_comb begin
    state_nxt = state;
    cnt_load  = 1'b0;
    case (state)
      IDLE: begin
        if (banks_pending >= PEND_TRAIN) begin
          state_nxt = TRAIN;
          cnt_load  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      TRAIN: begin
        if (cnt_tc) begin
          state_nxt = DECODE;
          cnt_load  = 1'b1;
        end else begin
          state_nxt = TRAIN;
        end
      end
      DECODE: begin
        if (!cnt_tc) begin
          state_nxt = DECODE;
        end else if (pending_nxt >= PEND_TRAIN) begin
          state_nxt = TRAIN;
          cnt_load  = 1'b1;
        end else begin
          state_nxt = IDLE;
        end
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  // Counter runs only while an epoch continues; it parks at zero when going idle.
  assign cnt_en = (state != IDLE) & (state_nxt != IDLE);

  tbs_dncnt u_dncnt (
    .clk       (clk),
    .rst       (rst),
    .load      (cnt_load),
    .en        (cnt_en),
    .load_val  (ADDR_LAST),
    .count_nxt (cnt_nxt),
    .tc        (cnt_tc)
  );

  // Scheduler state, bookkeeping and write pointers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= IDLE;
      oldest        <= 2'd0;
      banks_pending <= 2'd0;
      in_ready      <= 1'b0;
      wr_bank       <= 2'd0;
      wr_addr       <= 4'd0;
    end else begin
      state         <= state_nxt;
      oldest        <= oldest_nxt;
      banks_pending <= pending_nxt;
      // Registered from the next pending count so it tracks banks_pending exactly.
      in_ready      <= (pending_nxt < PEND_FULL);
      if (wr_en) begin
        wr_addr <= wr_addr + 4'd1;
        if (wr_addr == ADDR_LAST) begin
          wr_bank <= bank_inc(wr_bank);
        end
      end
    end
  end

  // TBU control lags the FSM by one cycle to line up with synchronous read data.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      tbu_enable    <= 1'b0;
      tbu_selection <= 1'b0;
      epoch_done    <= 1'b0;
    end else begin
      tbu_enable    <= (state != IDLE);
      tbu_selection <= (state == DECODE);
      epoch_done    <= dec_done;
    end
  end

  // Read ports are loaded from next-state values so the address is valid in the
  // same cycle as the state it belongs to; an unused port keeps its last value.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_bank_0 <= 2'd0;
      rd_addr_0 <= 4'd0;
      rd_bank_1 <= 2'd0;
      rd_addr_1 <= 4'd0;
    end else begin
      if (state_nxt == TRAIN) begin
        rd_bank_0 <= bank_inc(oldest_nxt);
        rd_addr_0 <= cnt_nxt;
      end
      if (state_nxt == DECODE) begin
        rd_bank_1 <= oldest_nxt;
        rd_addr_1 <= cnt_nxt;
      end
    end
  end

endmodule

// File: tb/tb_tbu_sched.sv
// tb_tbu_sched: scoreboard bench for tbu_sched. An epoch-slot reference model
// (slot 0..15 training, 16..31 decoding, -1 idle) predicts every cycle's outputs;
// the driver pushes predictions, a separate monitor pops and compares them.
module tb_tbu_sched;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic       wr_en;
  logic [1:0] wr_bank;
  logic [3:0] wr_addr;
  logic [1:0] rd_bank_0;
  logic [3:0] rd_addr_0;
  logic [1:0] rd_bank_1;
  logic [3:0] rd_addr_1;
  logic       tbu_enable;
  logic       tbu_selection;
  logic       epoch_done;
  logic [1:0] banks_pending;

  int checks = 0;
  int errors = 0;

  logic [24:0] exp_q[$];
  bit          mon_on = 1'b0;
  int          mode = 0;

  // Reference model state.
  int m_w, m_pend, m_old, m_pos, m_rb0, m_ra0, m_rb1, m_ra1;
  bit m_rdy, m_en, m_sel, m_ep, drv_valid;

  logic [24:0] dut_vec;

  always #5 clk = ~clk;

  tbu_sched dut (
    .clk           (clk),
    .rst           (rst),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .wr_en         (wr_en),
    .wr_bank       (wr_bank),
    .wr_addr       (wr_addr),
    .rd_bank_0     (rd_bank_0),
    .rd_addr_0     (rd_addr_0),
    .rd_bank_1     (rd_bank_1),
    .rd_addr_1     (rd_addr_1),
    .tbu_enable    (tbu_enable),
    .tbu_selection (tbu_selection),
    .epoch_done    (epoch_done),
    .banks_pending (banks_pending)
  );

  assign dut_vec = {in_ready, wr_en, wr_bank, wr_addr, rd_bank_0, rd_addr_0,
                    rd_bank_1, rd_addr_1, tbu_enable, tbu_selection, epoch_done,
                    banks_pending};

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  function automatic logic [24:0] exp_vec();
    logic [24:0] v;
    v = {m_rdy, drv_valid & m_rdy, 2'(m_w / 16), 4'(m_w % 16), 2'(m_rb0), 4'(m_ra0),
         2'(m_rb1), 4'(m_ra1), m_en, m_sel, m_ep, 2'(m_pend)};
    return v;
  endfunction

  task automatic model_reset();
    m_w = 0; m_pend = 0; m_old = 0; m_pos = -1;
    m_rb0 = 0; m_ra0 = 0; m_rb1 = 0; m_ra1 = 0;
    m_rdy = 1'b0; m_en = 1'b0; m_sel = 1'b0; m_ep = 1'b0; drv_valid = 1'b0;
  endtask

  // One clock edge of the reference model, using the input driven last cycle.
  task automatic model_step();
    bit acc, bdone, last;
    int np;
    acc   = drv_valid && m_rdy;
    bdone = acc && (m_w % 16 == 15);
    last  = (m_pos == 31);
    m_en  = (m_pos >= 0);
    m_sel = (m_pos >= 16);
    m_ep  = last;
    np = m_pend + (bdone ? 1 : 0) - (last ? 1 : 0);
    if (last) m_old = (m_old + 1) % 4;
    if (m_pos < 0) begin
      if (m_pend >= 2) m_pos = 0;
    end else if (m_pos < 31) begin
      m_pos++;
    end else begin
      m_pos = (np >= 2) ? 0 : -1;
    end
    m_pend = np;
    if (acc) m_w = (m_w + 1) % 64;
    m_rdy = (np < 3);
    if (m_pos >= 0 && m_pos < 16) begin
      m_rb0 = (m_old + 1) % 4;
      m_ra0 = 15 - m_pos;
    end else if (m_pos >= 16) begin
      m_rb1 = m_old;
      m_ra1 = 31 - m_pos;
    end
  endtask

  // Advance one clock, pick this cycle's in_valid and queue the prediction.
  task automatic cycle();
    @(posedge clk);
    #1;
    model_step();
    case (mode)
      0:       drv_valid = 1'b1;
      1:       drv_valid = ($urandom_range(0, 3) != 0);
      2:       drv_valid = ~drv_valid;
      3:       drv_valid = (m_w < 32) || (m_pos >= 16 && m_w < 48);
      default: drv_valid = 1'b0;
    endcase
    in_valid = drv_valid;
    exp_q.push_back(exp_vec());
    mon_on = 1'b1;
  endtask

  // Asynchronous reset mid-cycle; outputs must clear without waiting for an edge.
  task automatic do_reset();
    #2;
    mon_on = 1'b0;
    exp_q.delete();
    in_valid = 1'b0;
    rst = 1'b0;
    #1;
    check("reset_outputs", {7'd0, dut_vec}, 32'd0);
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  // Monitor: compare outputs each cycle and time back-to-back epochs.
  initial begin
    int  since_ep;
    bit  gap;
    logic [24:0] e;
    since_ep = -1;
    gap = 1'b0;
    forever begin
      @(negedge clk);
      if (!mon_on) begin
        since_ep = -1;
        gap = 1'b0;
      end else begin
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL scoreboard_empty actual=0 required=1 at %0t", $time);
        end else begin
          e = exp_q.pop_front();
          check("cycle_outputs", {7'd0, dut_vec}, {7'd0, e});
        end
        if (epoch_done) begin
          if (since_ep >= 0 && !gap) check("epoch_period", since_ep + 1, 32);
          since_ep = 0;
          gap = 1'b0;
        end else if (since_ep >= 0) begin
          since_ep++;
          if (!tbu_enable) gap = 1'b1;
        end
      end
    end
  end

  initial begin
    int  n;
    int  ep_cnt;
    bit  hit;
    rst = 1'b1;
    in_valid = 1'b0;
    model_reset();
    do_reset();

    // Continuous input: fill, saturate, steady-state epochs, bank wrap.
    mode = 0;
    ep_cnt = 0;
    for (int i = 0; i < 300; i++) begin
      cycle();
      #3;
      if (m_ep) ep_cnt++;
      if (ep_cnt == 3 && m_pos == 0)  check("wrap_train_bank", rd_bank_0, 0);
      if (ep_cnt == 3 && m_pos == 16) check("wrap_decode_bank", rd_bank_1, 3);
    end

    // Reset while decoding with counter = 7.
    hit = 1'b0;
    for (int i = 0; i < 80 && !hit; i++) begin
      cycle();
      if (m_pos == 24) hit = 1'b1;
    end
    check("reach_decode_7", hit, 1);
    #1;
    check("pre_reset_sel", tbu_selection, 1);
    check("pre_reset_addr", rd_addr_1, 7);
    do_reset();
    // 32 writes fill two banks, plus one write while IDLE sees two pending
    // and one during the first TRAIN cycle before tbu_enable rises.
    n = 0;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycle();
      #3;
      if (tbu_enable) hit = 1'b1;
      else if (wr_en) n++;
    end
    check("post_reset_enable_seen", hit, 1);
    check("post_reset_writes", n, 34);

    // Bank completion aligned with the last decode cycle.
    do_reset();
    mode = 3;
    hit = 1'b0;
    for (int i = 0; i < 200 && !hit; i++) begin
      cycle();
      if (m_ep) hit = 1'b1;
    end
    check("coincide_seen", hit, 1);
    #3;
    check("coincide_pending", banks_pending, 2);
    check("coincide_sel_high", tbu_selection, 1);
    cycle();
    #3;
    check("coincide_sel_low", tbu_selection, 0);
    check("coincide_no_gap", tbu_enable, 1);

    // Toggling input, then random gaps.
    do_reset();
    mode = 2;
    for (int i = 0; i < 400; i++) cycle();
    mode = 1;
    for (int i = 0; i < 800; i++) cycle();

    @(negedge clk);
    #1;
    mon_on = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
